// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler: synchronize, glitch-filter and accumulate a ripple counter value; RCS_SETTLE_TIMEOUT_EN adds a settle timeout with settle_err
module ripple_count_sampler #(
  parameter int CNT_W      = 4,
  parameter int ACC_W      = 16,
  parameter int STABLE_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             sample_req,
  input  logic [ACC_W-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] out_delta,
  output logic [ACC_W-1:0] total,
  output logic             thresh_hit,
  output logic             overflow,
  output logic             busy
`ifdef RCS_SETTLE_TIMEOUT_EN
  ,
  output logic             settle_err
`endif
);
  typedef enum logic [1:0] {IDLE, SETTLE, EMIT} state_t;
  state_t           state;
  logic [CNT_W-1:0] s1, s2, cand, last, delta;
  logic [3:0]       stab;
  logic [ACC_W:0]   sum;
  logic             stable_hit, accept;
  assign delta      = cand - last;
  assign sum        = {1'b0, total} + {{(ACC_W + 1 - CNT_W){1'b0}}, delta};
  assign stable_hit = state == SETTLE && s2 == cand && stab + 4'd1 == 4'(STABLE_CYC);
  assign busy       = state != IDLE;
`ifdef RCS_SETTLE_TIMEOUT_EN
  logic [4:0] tmo;
  assign accept = stable_hit || (state == SETTLE && tmo == 5'd31);
`else
  assign accept = stable_hit;
`endif
  // two-flop synchronizer for the asynchronous ripple value
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= cnt_in;
      s2 <= s1;
    end
  end
  // sample / settle / emit control with registered results
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cand       <= '0;
      last       <= '0;
      stab       <= '0;
      out_count  <= '0;
      out_delta  <= '0;
      total      <= '0;
      out_valid  <= 1'b0;
      thresh_hit <= 1'b0;
      overflow   <= 1'b0;
`ifdef RCS_SETTLE_TIMEOUT_EN
      tmo        <= '0;
      settle_err <= 1'b0;
`endif
    end else begin
      thresh_hit <= total >= thresh;
      case (state)
        IDLE: if (sample_req) begin
          cand  <= s2;
          stab  <= 4'd1;
          state <= SETTLE;
`ifdef RCS_SETTLE_TIMEOUT_EN
          tmo   <= '0;
`endif
        end
        SETTLE: begin
`ifdef RCS_SETTLE_TIMEOUT_EN
          tmo <= tmo + 5'd1;
`endif
          if (accept) begin
            out_count <= cand;
            out_delta <= delta;
            last      <= cand;
            total     <= sum[ACC_W-1:0];
            overflow  <= overflow | sum[ACC_W];
            out_valid <= 1'b1;
            state     <= EMIT;
`ifdef RCS_SETTLE_TIMEOUT_EN
            settle_err <= !stable_hit;
`endif
          end else if (s2 == cand) begin
            stab <= stab + 4'd1;
          end else begin
            cand <= s2;
            stab <= 4'd1;
          end
        end
        EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
`ifdef RCS_SETTLE_TIMEOUT_EN
          settle_err <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ripple_count_sampler.sv
// tb_ripple_count_sampler: directed self-checking bench for ripple_count_sampler
module tb_ripple_count_sampler;
  logic        clk = 1'b0;
  logic        reset, sample_req, out_ready, out_valid, thresh_hit, overflow, busy;
  logic [3:0]  cnt_in, out_count, out_delta;
  logic [15:0] thresh, total;
`ifdef RCS_SETTLE_TIMEOUT_EN
  logic        settle_err;
`endif
  int          checks = 0, errors = 0;
  logic [3:0]  m_last, v;
  logic [15:0] m_total, d;
  int          n;

  always #5 clk = ~clk;

  ripple_count_sampler dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .sample_req(sample_req),
    .thresh(thresh), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_delta(out_delta), .total(total),
    .thresh_hit(thresh_hit), .overflow(overflow), .busy(busy)
`ifdef RCS_SETTLE_TIMEOUT_EN
    , .settle_err(settle_err)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int lim, output int cnt);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < lim) begin
      tick;
      cnt++;
    end
  endtask

  task automatic sample(input logic [3:0] val, input logic [3:0] ed, input logic [15:0] et);
    int k;
    cnt_in = val;
    tick;
    tick;
    sample_req = 1'b1;
    tick;
    sample_req = 1'b0;
    wait_valid(40, k);
    chk("s_valid", out_valid, 1);
    chk("s_count", out_count, val);
    chk("s_delta", out_delta, ed);
    chk("s_total", total, et);
    tick;
    chk("s_drop", out_valid, 0);
  endtask

  initial begin
    // reset with active inputs
    reset = 1'b0; cnt_in = 4'hA; sample_req = 1'b1; out_ready = 1'b0; thresh = 16'hFFFF;
    repeat (3) tick;
    chk("rst_valid", out_valid, 0);
    chk("rst_count", out_count, 0);
    chk("rst_delta", out_delta, 0);
    chk("rst_total", total, 0);
    chk("rst_thresh", thresh_hit, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1; sample_req = 1'b0;
    tick;
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    // single sample, valid for exactly one cycle
    cnt_in = 4'd5; out_ready = 1'b1;
    tick;
    tick;
    sample_req = 1'b1;
    tick;
    sample_req = 1'b0;
    chk("t2_busy", busy, 1);
    chk("t2_nvalid", out_valid, 0);
    tick;
    chk("t2_valid", out_valid, 1);
    chk("t2_count", out_count, 5);
    chk("t2_delta", out_delta, 5);
    chk("t2_total", total, 5);
    tick;
    chk("t2_drop", out_valid, 0);
    chk("t2_idle", busy, 0);
    // wrap of the ripple counter
    sample(4'd14, 4'd9, 16'd14);
    sample(4'd3, 4'd5, 16'd19);
    // glitching input is filtered until it settles
    for (int i = 0; i < 6; i++) begin
      cnt_in = (i % 2 == 0) ? 4'd6 : 4'd7;
      sample_req = (i == 2);
      tick;
      chk("t4_noval", out_valid, 0);
    end
    sample_req = 1'b0;
    cnt_in = 4'd7;
    wait_valid(20, n);
    chk("t4_lat", n, 3);
    chk("t4_count", out_count, 7);
    chk("t4_delta", out_delta, 4);
    chk("t4_total", total, 23);
    tick;
    chk("t4_drop", out_valid, 0);
    // backpressure holds result, extra request ignored
    out_ready = 1'b0; cnt_in = 4'd9;
    tick;
    tick;
    sample_req = 1'b1;
    tick;
    sample_req = 1'b0;
    tick;
    chk("t5_valid", out_valid, 1);
    chk("t5_count", out_count, 9);
    chk("t5_delta", out_delta, 2);
    chk("t5_total", total, 25);
    for (int i = 0; i < 5; i++) begin
      sample_req = (i == 1);
      if (i == 1) cnt_in = 4'd12;
      tick;
      chk("t5_hold_v", out_valid, 1);
      chk("t5_hold_c", out_count, 9);
      chk("t5_hold_t", total, 25);
    end
    sample_req = 1'b0; out_ready = 1'b1;
    tick;
    chk("t5_drop", out_valid, 0);
    chk("t5_idle", busy, 0);
    repeat (4) begin
      tick;
      chk("t5_noreq", out_valid, 0);
    end
    chk("t5_total2", total, 25);
    // reset during EMIT aborts the result
    out_ready = 1'b0;
    sample_req = 1'b1;
    tick;
    sample_req = 1'b0;
    tick;
    chk("t5b_valid", out_valid, 1);
    chk("t5b_total", total, 28);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_total", total, 0);
    out_ready = 1'b1;
    tick;
    // threshold flag lags the total by one edge
    thresh = 16'd10;
    sample(4'd4, 4'd4, 16'd4);
    chk("th_4", thresh_hit, 0);
    sample(4'd8, 4'd4, 16'd8);
    chk("th_8", thresh_hit, 0);
    cnt_in = 4'd12;
    tick;
    tick;
    sample_req = 1'b1;
    tick;
    sample_req = 1'b0;
    tick;
    chk("th_total", total, 12);
    chk("th_lag", thresh_hit, 0);
    tick;
    chk("th_hit", thresh_hit, 1);
    chk("th_drop", out_valid, 0);
    // climb to 0xFFFE, then overflow
    m_last = 4'd12; m_total = 16'd12;
    while (m_total != 16'hFFFE) begin
      d = (16'hFFFE - m_total > 16'd15) ? 16'd15 : 16'hFFFE - m_total;
      m_last = m_last + d[3:0];
      m_total = m_total + d;
      sample(m_last, d[3:0], m_total);
    end
    chk("ovf_pre", overflow, 0);
    v = m_last + 4'd5;
    sample(v, 4'd5, 16'h0003);
    chk("ovf_set", overflow, 1);
    v = v + 4'd1;
    sample(v, 4'd1, 16'h0004);
    chk("ovf_sticky", overflow, 1);
    v = v + 4'd0;
    sample(v, 4'd0, 16'h0004);
    chk("ovf_sticky2", overflow, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
